// File: rtl/lsu_byte_serial_pkg.sv
`default_nettype none
// ============================================================================
// lsu_byte_serial_pkg : shared memory-width enum, FSM states and byte counts
// Rev 1.0
// ============================================================================
package lsu_byte_serial_pkg;

    typedef enum logic [1:0] {
        BITS8  = 2'd0,
        BITS16 = 2'd1,
        BITS32 = 2'd2
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } lsu_state_e;

    localparam logic [1:0] WIDTH_ILLEGAL = 2'd3;

    function automatic logic [2:0] width_bytes(input mem_width_e width);
        case (width)
            BITS8:   width_bytes = 3'd1;
            BITS16:  width_bytes = 3'd2;
            BITS32:  width_bytes = 3'd4;
            default: width_bytes = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_serial_load_extend.sv
`default_nettype none
// ============================================================================
// lsu_byte_serial_load_extend : sign/zero extension of an assembled load word
// Rev 1.0
// ============================================================================
module lsu_byte_serial_load_extend
    import lsu_byte_serial_pkg::*;
(
    input  logic [31:0] acc,
    input  mem_width_e  width,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = acc;
        case (width)
            BITS8:   rdata = {{24{sign_ext & acc[7]}},  acc[7:0]};
            BITS16:  rdata = {{16{sign_ext & acc[15]}}, acc[15:0]};
            default: rdata = acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_byte_serial.sv
`default_nettype none
// ============================================================================
// lsu_byte_serial : byte-serial little-endian load/store unit for an 8-bit Ram
// Rev 1.0
// ============================================================================
module lsu_byte_serial
    import lsu_byte_serial_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CNT_W = IDX_W + 1;

    lsu_state_e         state;
    logic [31:0]        addr_q;
    mem_width_e         width_q;
    logic               signed_q;
    logic               write_q;
    logic [31:0]        wdata_q;
    logic [31:0]        acc_q;
    logic [IDX_W-1:0]   idx;

    logic               xfer;
    logic               last;
    logic [CNT_W-1:0]   nbytes;
    logic [31:0]        acc_next;
    logic [31:0]        wdata_shift;
    logic [31:0]        ext_rdata;

    assign xfer   = (state == ST_XFER);
    assign nbytes = CNT_W'(width_bytes(width_q));
    assign last   = (({1'b0, idx} + CNT_W'(1)) == nbytes);

    // Ram port is decoded from state so an async reset drops mem_we at once
    assign wdata_shift = wdata_q >> {idx, 3'b000};
    assign mem_addr    = xfer ? (addr_q + 32'(idx)) : 32'd0;
    assign mem_we      = xfer & write_q;
    assign mem_wdata   = xfer ? wdata_shift[7:0] : 8'd0;

    always_comb begin
        acc_next = acc_q;
        acc_next[{idx, 3'b000} +: 8] = mem_rdata;
    end

    // Extension sees the final byte merged in, so rdata is ready with done
    lsu_byte_serial_load_extend u_load_extend (
        .acc      (acc_next),
        .width    (width_q),
        .sign_ext (signed_q),
        .rdata    (ext_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= 32'd0;
            width_q  <= BITS8;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'd0;
            acc_q    <= 32'd0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        width_q  <= mem_width_e'(req_width);
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        wdata_q  <= req_wdata;
                        acc_q    <= 32'd0;
                        idx      <= '0;
                        if (req_width == WIDTH_ILLEGAL) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= 32'd0;
                        end else begin
                            state <= ST_XFER;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (!write_q) begin
                        acc_q <= acc_next;
                    end
                    if (last) begin
                        state <= ST_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        rdata <= write_q ? 32'd0 : ext_rdata;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
